// File: rtl/dff_pipe_chain.sv
// Elastic register chain: DEPTH valid/data stages with bubble collapse, backpressure,
// synchronous clear, asynchronous reset and a registered occupancy count.

module dff_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             clr,
  input  logic             i_load,
  input  logic             i_drain,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_v,
  output logic [WIDTH-1:0] o_q
);

  logic             r_v;
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_v <= 1'b0;
      r_q <= RESET_VAL;
    end else if (clr) begin
      r_v <= 1'b0;
    end else if (i_load) begin
      r_v <= 1'b1;
      r_q <= i_d;
    end else if (i_drain) begin
      r_v <= 1'b0;
    end
  end

  assign o_v = r_v;
  assign o_q = r_q;

endmodule

module dff_pipe_chain #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            w_v;
  logic [DEPTH-1:0]            w_mv;
  logic [DEPTH-1:0]            w_load;
  logic [DEPTH-1:0][WIDTH-1:0] w_q;
  logic                        w_acc;
  logic                        w_out;
  logic [OCC_W-1:0]            r_occ;

  // Unrolled move chain: a stage moves if any stage ahead is empty or the
  // consumer takes the head, so no bit of w_mv depends on another.
  assign w_mv[DEPTH-1] = w_v[DEPTH-1] & out_ready;
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH-1; gi++) begin : g_mv
      assign w_mv[gi] = w_v[gi] & (out_ready | ~(&w_v[DEPTH-1:gi+1]));
    end
  endgenerate

  assign in_ready  = (~w_v[0] | w_mv[0]) & ~clr & ~areset;
  assign out_valid = w_v[DEPTH-1] & ~clr;
  assign out_data  = w_q[DEPTH-1];
  assign w_acc     = in_valid & in_ready;
  assign w_out     = out_valid & out_ready;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] w_d;
      if (gi == 0) begin : g_head
        assign w_load[gi] = w_acc;
        assign w_d        = in_data;
      end else begin : g_body
        assign w_load[gi] = w_mv[gi-1];
        assign w_d        = w_q[gi-1];
      end
      dff_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .clk     (clk),
        .areset  (areset),
        .clr     (clr),
        .i_load  (w_load[gi]),
        .i_drain (w_mv[gi]),
        .i_d     (w_d),
        .o_v     (w_v[gi]),
        .o_q     (w_q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge areset) begin
    if (areset)              r_occ <= '0;
    else if (clr)            r_occ <= '0;
    else if (w_acc & ~w_out) r_occ <= r_occ + 1'b1;
    else if (w_out & ~w_acc) r_occ <= r_occ - 1'b1;
  end

  assign occupancy = r_occ;

endmodule

// File: tb/tb_dff_pipe_chain.sv
// Directed + random bench for dff_pipe_chain (DEPTH=4, WIDTH=8) against a
// queue-of-beats model that tracks each beat's position in the chain.
module tb_dff_pipe_chain;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       areset, clr, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [7:0] d; int pos; } beat_t;
  beat_t mq[$];

  dff_pipe_chain #(.WIDTH(8), .DEPTH(D), .RESET_VAL(8'h00)) dut (
    .clk(clk), .areset(areset), .clr(clr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from a negedge, check combinational outputs, update the
  // model at the posedge and return at the next negedge.
  task automatic step(input bit iv, input bit [7:0] id, input bit ordy, input bit c);
    bit exp_ov, exp_ir, outf, acc;
    in_valid = iv; in_data = id; out_ready = ordy; clr = c;
    #1;
    exp_ov = (mq.size() > 0) && (mq[0].pos == D-1) && !c;
    outf   = exp_ov && ordy;
    exp_ir = !c && ((mq.size() < D) || outf);
    acc    = iv && exp_ir;
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
    if (exp_ov) chk("out_data", {24'b0, out_data}, {24'b0, mq[0].d});
    chk("occupancy", {29'b0, occupancy}, mq.size());
    @(posedge clk);
    if (c) mq.delete();
    else begin
      foreach (mq[j])
        if (outf || ((D-1-mq[j].pos) > j)) mq[j].pos = mq[j].pos + 1;
      if (outf) void'(mq.pop_front());
      if (acc) mq.push_back('{d: id, pos: 0});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, ordy, 1'b0);
  endtask

  initial begin
    areset = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_data", {24'b0, out_data}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_occupancy", {29'b0, occupancy}, 0);
    areset = 1'b0;

    // latency: single beat, free-flowing consumer
    step(1'b1, 8'hA1, 1'b1, 1'b0);
    idle(5, 1'b1);

    // backpressure fill then drain
    for (int k = 0; k < 5; k++) step(1'b1, 8'h10 + 8'(k), 1'b0, 1'b0);
    chk("fill_occupancy", {29'b0, occupancy}, 4);
    #1 chk("fill_in_ready", {31'b0, in_ready}, 0);
    step(1'b1, 8'h14, 1'b1, 1'b0);
    idle(6, 1'b1);

    // bubble collapse
    step(1'b1, 8'h21, 1'b0, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("bubble_occupancy", {29'b0, occupancy}, 2);
    idle(4, 1'b1);

    // full streaming
    for (int k = 0; k < D; k++) step(1'b1, 8'h30 + 8'(k), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 8'h40 + 8'(k), 1'b1, 1'b0);
    chk("stream_occupancy", {29'b0, occupancy}, 4);
    idle(6, 1'b1);

    // clear with three beats in flight
    for (int k = 0; k < 3; k++) step(1'b1, 8'h50 + 8'(k), 1'b0, 1'b0);
    step(1'b1, 8'h5F, 1'b1, 1'b1);
    chk("clr_occupancy", {29'b0, occupancy}, 0);
    idle(5, 1'b1);

    // asynchronous reset mid-stream
    for (int k = 0; k < 3; k++) step(1'b1, 8'h60 + 8'(k), 1'b0, 1'b0);
    #2 areset = 1'b1;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 0);
    chk("arst_out_data", {24'b0, out_data}, 0);
    chk("arst_in_ready", {31'b0, in_ready}, 0);
    chk("arst_occupancy", {29'b0, occupancy}, 0);
    mq.delete();
    @(negedge clk);
    areset = 1'b0;

    // random traffic
    for (int k = 0; k < 3000; k++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
           $urandom_range(0, 29) == 0);
    idle(6, 1'b1);
    chk("final_occupancy", {29'b0, occupancy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
